// File: rtl/clk_monitor_pkg.sv
// clk_monitor_pkg: shared types and default sizing for the divided-clock checker.
//   state_e          - monitor FSM states
//   *_DEF constants  - default parameter values for clk_monitor
//   GC_W             - width of the good-measurement counter (LOCK_CNT <= 15)
package clk_monitor_pkg;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned LOCK_CNT_DEF    = 4;
  localparam int unsigned GC_W            = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-stage synchronizer for an asynchronous level, followed by
// a registered any-edge (rising or falling) detector.
// Ports:
//   clk        - sampling clock
//   rst_n      - asynchronous active-low reset, clears every stage to 0
//   async_in   - asynchronous input level
//   edge_pulse - one-cycle pulse, SYNC_STAGES+1 cycles after an input transition
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_pulse
);

  localparam int unsigned MSB = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain, delayed copy of its last stage and registered XOR edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[MSB-1:0], async_in};
      prev_q     <= sync_q[MSB];
      edge_pulse <= sync_q[MSB] ^ prev_q;
    end
  end

endmodule

// File: rtl/clk_monitor.sv
// clk_monitor: measures every half-period of an asynchronous divided clock in
// clk cycles and checks it against exp_half +/- tol.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   en           - monitor enable (level)
//   mon_clk      - monitored clock, asynchronous to clk
//   exp_half     - expected half-period in clk cycles
//   tol          - allowed absolute deviation in clk cycles
//   half_period  - last measured half-period (saturated to CNT_W bits)
//   meas_valid   - one-cycle pulse when half_period updates
//   locked       - LOCK_CNT consecutive good measurements, no error since
//   err          - one-cycle pulse on a bad measurement or a timeout
//   stuck        - mon_clk has not toggled within exp_half+tol cycles
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned LOCK_CNT    = LOCK_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mon_clk,
  input  logic [CNT_W-1:0] exp_half,
  input  logic [CNT_W-1:0] tol,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             stuck
);

  localparam int unsigned MW = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GC_W-1:0]  LOCK_GC = GC_W'(LOCK_CNT);

  logic mon_edge;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GC_W-1:0]  gc_q, gc_d;
  logic [CNT_W-1:0] half_d;
  logic             mv_d, locked_d, err_d, stuck_d;

  logic [MW-1:0]    meas_w, exp_w, tol_w, limit_w, diff_w;
  logic [CNT_W-1:0] meas_sat, cnt_inc;
  logic [GC_W-1:0]  gc_inc;
  logic             in_tol, timeout;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (mon_clk),
    .edge_pulse (mon_edge)
  );

  // Measurement arithmetic is done one bit wider so neither the sum nor the
  // difference can wrap.
  always_comb begin
    meas_w   = {1'b0, cnt_q} + MW'(1);
    exp_w    = {1'b0, exp_half};
    tol_w    = {1'b0, tol};
    limit_w  = exp_w + tol_w;
    diff_w   = (meas_w >= exp_w) ? (meas_w - exp_w) : (exp_w - meas_w);
    in_tol   = (diff_w <= tol_w);
    meas_sat = meas_w[CNT_W] ? CNT_MAX : meas_w[CNT_W-1:0];
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));
    gc_inc   = (gc_q == LOCK_GC) ? gc_q : (gc_q + GC_W'(1));
    timeout  = !mon_edge && (meas_w > limit_w) && !stuck;
  end

  // Next-state and next-output logic; disable overrides every state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gc_d     = gc_q;
    half_d   = half_period;
    mv_d     = 1'b0;
    err_d    = 1'b0;
    locked_d = locked;
    stuck_d  = stuck;

    if (!en) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      gc_d     = '0;
      locked_d = 1'b0;
      stuck_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
          cnt_d   = '0;
        end
        // First interval is partial, so the first edge only starts the count.
        ST_ACQUIRE: begin
          if (mon_edge) begin
            state_d = ST_TRACK;
            cnt_d   = '0;
          end
        end
        // An edge takes priority over a coincident timeout.
        ST_TRACK: begin
          if (mon_edge) begin
            half_d  = meas_sat;
            mv_d    = 1'b1;
            cnt_d   = '0;
            stuck_d = 1'b0;
            if (in_tol) begin
              gc_d = gc_inc;
              if (gc_inc == LOCK_GC) locked_d = 1'b1;
            end else begin
              err_d    = 1'b1;
              gc_d     = '0;
              locked_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_inc;
            if (timeout) begin
              stuck_d  = 1'b1;
              err_d    = 1'b1;
              locked_d = 1'b0;
              gc_d     = '0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          gc_d    = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gc_q        <= '0;
      half_period <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      stuck       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gc_q        <= gc_d;
      half_period <= half_d;
      meas_valid  <= mv_d;
      locked      <= locked_d;
      err         <= err_d;
      stuck       <= stuck_d;
    end
  end

endmodule

// File: tb/tb_clk_monitor.sv
// tb_clk_monitor: directed scenarios for clk_monitor (16-bit main instance and a
// 4-bit instance for counter saturation).
module tb_clk_monitor;

  logic        clk;
  logic        rst_n;
  logic        en, mon_clk;
  logic [15:0] exp_half, tol, half_period;
  logic        meas_valid, locked, err, stuck;

  logic        en_s, mon_s;
  logic [3:0]  exp_s, tol_s, half_s;
  logic        mv_s, locked_s, err_s, stuck_s;

  int total = 0;
  int bad   = 0;

  int          n_meas, n_err, n_meas_s, n_err_s;
  logic [15:0] last_half;
  logic [3:0]  last_half_s;

  clk_monitor #(.CNT_W(16), .SYNC_STAGES(2), .LOCK_CNT(4)) dut (
    .clk (clk), .rst_n (rst_n), .en (en), .mon_clk (mon_clk),
    .exp_half (exp_half), .tol (tol), .half_period (half_period),
    .meas_valid (meas_valid), .locked (locked), .err (err), .stuck (stuck)
  );

  clk_monitor #(.CNT_W(4), .SYNC_STAGES(2), .LOCK_CNT(4)) dut_sat (
    .clk (clk), .rst_n (rst_n), .en (en_s), .mon_clk (mon_s),
    .exp_half (exp_s), .tol (tol_s), .half_period (half_s),
    .meas_valid (mv_s), .locked (locked_s), .err (err_s), .stuck (stuck_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record pulses shortly after each active edge.
  always @(posedge clk) begin
    #1;
    if (meas_valid === 1'b1) begin n_meas++; last_half = half_period; end
    if (err === 1'b1) n_err++;
    if (mv_s === 1'b1) begin n_meas_s++; last_half_s = half_s; end
    if (err_s === 1'b1) n_err_s++;
  end

  task automatic clear_obs();
    n_meas = 0; n_err = 0; n_meas_s = 0; n_err_s = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    mon_clk = ~mon_clk;
  endtask

  task automatic step_s(input int n);
    repeat (n) @(negedge clk);
    mon_s = ~mon_s;
  endtask

  task automatic test_reset();
    wait_cyc(2);
    total++; if (half_period !== 16'd0) begin bad++; $display("FAIL reset_half got=%0d want=0", half_period); end
    total++; if ({meas_valid, locked, err, stuck} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {meas_valid, locked, err, stuck}); end
    rst_n = 1'b1;
    wait_cyc(2);
  endtask

  task automatic test_nominal_lock();
    exp_half = 16'd11; tol = 16'd0; en = 1'b1;
    wait_cyc(2);
    clear_obs();
    step(3);
    step(11); wait_cyc(5);
    total++; if (n_meas !== 1) begin bad++; $display("FAIL nom_first_meas got=%0d want=1", n_meas); end
    total++; if (last_half !== 16'd11) begin bad++; $display("FAIL nom_half got=%0d want=11", last_half); end
    step(6); step(11); wait_cyc(5);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL nom_early_lock got=%b want=0", locked); end
    step(6); wait_cyc(5);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL nom_lock got=%b want=1", locked); end
    total++; if (n_meas !== 4 || n_err !== 0) begin bad++; $display("FAIL nom_counts meas=%0d err=%0d want 4/0", n_meas, n_err); end
  endtask

  task automatic test_timeout();
    clear_obs();
    wait_cyc(20);
    total++; if ({stuck, locked} !== 2'b10) begin bad++; $display("FAIL to_stuck stuck/locked=%b want=10", {stuck, locked}); end
    total++; if (n_err !== 1) begin bad++; $display("FAIL to_err_once got=%0d want=1", n_err); end
    wait_cyc(1000);
    total++; if (n_err !== 1 || stuck !== 1'b1) begin bad++; $display("FAIL to_no_repeat err=%0d stuck=%b want 1/1", n_err, stuck); end
    step(1); wait_cyc(5);
    total++; if (stuck !== 1'b0 || n_err !== 2 || n_meas !== 1) begin bad++; $display("FAIL to_resume stuck=%b err=%0d meas=%0d want 0/2/1", stuck, n_err, n_meas); end
    total++; if (!(last_half > 16'd11)) begin bad++; $display("FAIL to_resume_half got=%0d want>11", last_half); end
    step(6); step(11); step(11); step(11); wait_cyc(5);
    total++; if (locked !== 1'b1 || n_err !== 2) begin bad++; $display("FAIL to_relock locked=%b err=%0d want 1/2", locked, n_err); end
  endtask

  task automatic test_enable_drop();
    clear_obs();
    en = 1'b0;
    wait_cyc(1);
    total++; if ({locked, stuck} !== 2'b00) begin bad++; $display("FAIL en_clear locked/stuck=%b want=00", {locked, stuck}); end
    total++; if (half_period !== 16'd11) begin bad++; $display("FAIL en_half_kept got=%0d want=11", half_period); end
    wait_cyc(3);
    total++; if (n_err !== 0 || n_meas !== 0) begin bad++; $display("FAIL en_no_pulse err=%0d meas=%0d want 0/0", n_err, n_meas); end
    en = 1'b1;
    wait_cyc(3);
    step(1); wait_cyc(5);
    total++; if (n_meas !== 0) begin bad++; $display("FAIL en_first_edge got=%0d want=0", n_meas); end
    step(6); wait_cyc(5);
    total++; if (n_meas !== 1 || last_half !== 16'd11 || n_err !== 0) begin bad++; $display("FAIL en_remeasure meas=%0d half=%0d err=%0d want 1/11/0", n_meas, last_half, n_err); end
  endtask

  task automatic test_tolerance();
    en = 1'b0; exp_half = 16'd100; tol = 16'd2;
    wait_cyc(2);
    en = 1'b1;
    wait_cyc(2);
    clear_obs();
    step(3);
    step(98); wait_cyc(5);
    total++; if (last_half !== 16'd98 || n_err !== 0) begin bad++; $display("FAIL tol_98 half=%0d err=%0d want 98/0", last_half, n_err); end
    step(97); wait_cyc(5);
    total++; if (last_half !== 16'd102 || n_err !== 0) begin bad++; $display("FAIL tol_102 half=%0d err=%0d want 102/0", last_half, n_err); end
    step(98); wait_cyc(5);
    total++; if (last_half !== 16'd103 || n_err !== 1 || locked !== 1'b0) begin bad++; $display("FAIL tol_103 half=%0d err=%0d locked=%b want 103/1/0", last_half, n_err, locked); end
    step(95); step(100); step(100); wait_cyc(5);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL tol_restart got=%b want=0", locked); end
    step(95); wait_cyc(5);
    total++; if (locked !== 1'b1 || n_err !== 1) begin bad++; $display("FAIL tol_relock locked=%b err=%0d want 1/1", locked, n_err); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (half_period !== 16'd0 || {meas_valid, locked, err, stuck} !== 4'b0000) begin bad++; $display("FAIL arst_immediate half=%0d flags=%b want 0/0000", half_period, {meas_valid, locked, err, stuck}); end
    mon_clk = 1'b0;
    wait_cyc(2);
    #2 rst_n = 1'b1;
    wait_cyc(3);
    clear_obs();
    total++; if (half_period !== 16'd0 || locked !== 1'b0) begin bad++; $display("FAIL arst_after half=%0d locked=%b want 0/0", half_period, locked); end
    step(2); wait_cyc(5);
    total++; if (n_meas !== 0) begin bad++; $display("FAIL arst_first_edge got=%0d want=0", n_meas); end
    step(6); wait_cyc(5);
    total++; if (n_meas !== 1 || last_half !== 16'd11) begin bad++; $display("FAIL arst_meas meas=%0d half=%0d want 1/11", n_meas, last_half); end
  endtask

  task automatic test_saturation();
    exp_s = 4'd15; tol_s = 4'd0; en_s = 1'b1;
    wait_cyc(2);
    clear_obs();
    step_s(3);
    step_s(20); wait_cyc(5);
    total++; if (n_meas_s !== 1 || last_half_s !== 4'd15) begin bad++; $display("FAIL sat_half meas=%0d half=%0d want 1/15", n_meas_s, last_half_s); end
    total++; if (n_err_s !== 2) begin bad++; $display("FAIL sat_err got=%0d want=2", n_err_s); end
    total++; if (stuck_s !== 1'b0) begin bad++; $display("FAIL sat_stuck got=%b want=0", stuck_s); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mon_clk = 1'b0; exp_half = 16'd11; tol = 16'd0;
    en_s = 1'b0; mon_s = 1'b0; exp_s = 4'd0; tol_s = 4'd0;
    last_half = '0; last_half_s = '0;
    clear_obs();
    test_reset();
    test_nominal_lock();
    test_timeout();
    test_enable_drop();
    test_tolerance();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_monitor.md
# clk_monitor

Checks a divided clock produced elsewhere in the design. It takes the slow clock `mon_clk` as a plain asynchronous input and synchronizes it into the `clk` domain. It measures every half-period (the `clk` cycles between consecutive `mon_clk` edges) and compares each one against a programmed expected value with tolerance. It reports lock, per-measurement results and error pulses, and serves as the sanity checker at the receiving end of the clock-divider path.

## Interface
- `CNT_W`, 16: width of the period counter, `exp_half`, `tol` and `half_period`.
- `SYNC_STAGES`, 2: flip-flop stages in the `mon_clk` synchronizer (≥2).
- `LOCK_CNT`, 4: consecutive in-tolerance half-periods required to assert `locked` (1..15).
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `en` in 1: monitor enable; level.
- `mon_clk` in 1: monitored clock, asynchronous to `clk`.
- `exp_half` in CNT_W: expected half-period in `clk` cycles; sampled continuously, static while `en`=1.
- `tol` in CNT_W: allowed absolute deviation in `clk` cycles.
- `half_period` out CNT_W: last measured half-period.
- `meas_valid` out 1: one-cycle pulse, `half_period` updated this cycle.
- `locked` out 1: level; `LOCK_CNT` consecutive good measurements and no error since.
- `err` out 1: one-cycle pulse on an out-of-tolerance measurement or a timeout.
- `stuck` out 1: level; `mon_clk` has not toggled within `exp_half+tol` cycles.

## Operation
- **Synchronizer and edge detect**
  - The synchronizer and edge detector run whenever out of reset, independent of `en`.
  - `edge` = XOR of the last two synchronized samples; both rising and falling edges count.
- **States**
  - **IDLE**: entered while `en`=0. Counter held at 0, good-count at 0, `locked`=0, `stuck`=0. `en`=1 → ACQUIRE.
  - **ACQUIRE**: waits for the first `edge`. No measurement is made, because the first interval is partial. On `edge`: counter ← 0 → TRACK.
  - **TRACK**:
    - Counter increments every cycle and saturates at 2^CNT_W−1.
    - On `edge`:
      - meas = counter+1.
      - `half_period` ← meas (saturated), `meas_valid` pulses, counter ← 0, `stuck` ← 0.
    - Measurement check:
      - Good if |meas − `exp_half`| ≤ `tol`, evaluated in CNT_W+1 bits with no wrap.
      - Good: good-count increments, saturating at `LOCK_CNT`. `locked` ← 1 when good-count reaches `LOCK_CNT`.
      - Bad: `err` pulses, good-count ← 0, `locked` ← 0.
    - **Timeout**:
      - Condition: no `edge` in a cycle where counter+1 > `exp_half`+`tol` (CNT_W+1-bit sum) and `stuck`=0.
      - Effect: `stuck` ← 1, `err` pulses once, `locked` ← 0, good-count ← 0.
      - No further timeout `err` while `stuck`=1.
    - `en`=0 → IDLE next cycle.
- **Simultaneous events**
  - `edge` in the same cycle as the timeout condition: the edge wins. The measurement is evaluated and no timeout fires.
  - An `edge` after a timeout still produces a measurement. That measurement is out of tolerance, so `err` pulses again.
- **Mid-operation changes**
  - `en` deasserted: `half_period` retains its last value, all other status clears, and no `err` is produced.
  - Reset mid-operation: all state and outputs return to reset values immediately.

## Timing
- Reset values: `half_period`=0, `meas_valid`=0, `locked`=0, `err`=0, `stuck`=0, state IDLE.
- Latency: a `mon_clk` transition reaches `edge` in SYNC_STAGES+1 `clk` cycles, ±1 cycle of metastability uncertainty.
- `meas_valid`, `half_period`, `err` and the `locked` rise are registered, appearing 1 cycle after `edge`. Total latency is SYNC_STAGES+2 cycles from the transition.
- Measurement accuracy: ±1 cycle per edge due to synchronization.
- `mon_clk` half-periods shorter than SYNC_STAGES+1 `clk` cycles are unsupported (edges may merge).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `clk_monitor_pkg`:
  - state enum (IDLE, ACQUIRE, TRACK);
  - default constants for `CNT_W`, `SYNC_STAGES`, `LOCK_CNT`.
- Sub-module `sync_edge_det`: `SYNC_STAGES`-deep synchronizer plus any-edge pulse output. It has the same `clk`/`rst_n` and resets all stages to 0.
- Top level: FSM, period counter, tolerance compare, good-count, output registers.

## Test plan
- **Nominal lock**: `exp_half`=11, `tol`=0, `mon_clk` toggling every 11 `clk` cycles, `en`=1. Required response:
  - first `meas_valid` on the second detected edge, with `half_period`=11;
  - `locked`=1 after the 4th good measurement;
  - `err` never asserts.
- **Tolerance boundary**: `exp_half`=100, `tol`=2, half-periods 98, 102, 103. Required response: the first two are good; 103 gives an `err` pulse, `locked`=0, and good-count restarts.
- **Timeout/stuck**: while locked at 11/0, hold `mon_clk` static. Required response:
  - counter+1=12 triggers `stuck`=1, a single `err` pulse and `locked`=0;
  - no further `err` over 1000 cycles;
  - resuming toggles produce `stuck`=0 and one out-of-tolerance `err`, then relock after 4 good measurements.
- **Enable drop**: deassert `en` mid-TRACK. Required response:
  - next cycle: IDLE, `locked`=0, `stuck`=0, `half_period` retained;
  - after re-enable, the first edge is not measured.
- **Async reset mid-measurement**: pulse `rst_n` low between `clk` edges. Required response: all outputs go to 0 immediately without waiting for `clk`; after release the block returns to IDLE.
- **Saturation**: `CNT_W`=4, `exp_half`=15, `tol`=0, `mon_clk` half-period 20. Required response: `half_period`=15, `err` pulses, and there is no wrap to a small value.
